rcv_mem_writer: RTL



---
 rtl/rcv_mem_writer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rcv_mem_writer.sv
// rtl/rcv_mem_writer.sv - writes framed stream records into a circular on-chip memory via its s1 port
// Each record is a header word (length, sequence) followed by data words; frames that do not fit are dropped.
module rcv_mem_writer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [1:0]        in_empty,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] address,
    output logic              clken,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    output logic              frame_done,
    output logic [15:0]       drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        HDR  = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W:0]   ONE_K = 1;
    localparam logic [ADDR_W:0]   TWO_K = 2;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   k_q, k_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              wen_q, wen_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       drop_q, drop_d;
    logic [15:0]       seq_q, seq_d;
    logic [15:0]       len_q, len_d;

    logic              beat;
    logic [ADDR_W-1:0] free;
    logic              room_sop;
    logic              room_data;
    logic              sop_beat;
    logic              data_beat;
    logic              sop_ok;
    logic              data_ok;
    logic              abort;
    logic [3:0]        eop_be;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;
    logic [ADDR_W:0]   words;

    assign in_ready = (state_q != HDR);
    assign beat     = in_valid & in_ready;

    // One slot is always left empty so rd_ptr == wr_ptr unambiguously means empty.
    assign free      = rd_ptr - wr_ptr_q - ONE_A;
    assign room_sop  = ({1'b0, free} >= TWO_K);
    assign room_data = ({1'b0, free} >= (k_q + ONE_K));

    // A sop in any accepting state starts a new record at the committed wr_ptr.
    assign sop_beat  = beat & in_sop;
    assign data_beat = beat & ~in_sop & (state_q == DATA);
    assign sop_ok    = sop_beat & room_sop;
    assign data_ok   = data_beat & room_data;
    assign abort     = sop_beat & (state_q == DATA);

    always_comb begin
        eop_be = 4'b1111;
        case (in_empty)
            2'd0: eop_be = 4'b1111;
            2'd1: eop_be = 4'b0111;
            2'd2: eop_be = 4'b0011;
            2'd3: eop_be = 4'b0001;
            default: eop_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            wr_ptr_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            wen_q        <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= '0;
            seq_q        <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            wr_ptr_q     <= wr_ptr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            wen_q        <= wen_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
            seq_q        <= seq_d;
            len_q        <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DATA, DROP: begin
                if (sop_beat) begin
                    if (room_sop) begin
                        state_d = in_eop ? HDR : DATA;
                    end else begin
                        state_d = in_eop ? IDLE : DROP;
                    end
                end else if (beat) begin
                    if (state_q == DATA) begin
                        if (room_data) begin
                            state_d = in_eop ? HDR : DATA;
                        end else begin
                            state_d = in_eop ? IDLE : DROP;
                        end
                    end else if (state_q == DROP) begin
                        state_d = in_eop ? IDLE : DROP;
                    end
                end
            end
            HDR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        k_d          = k_q;
        wr_ptr_d     = wr_ptr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        wen_d        = 1'b0;
        frame_done_d = 1'b0;
        seq_d        = seq_q;
        len_d        = len_q;
        words        = sop_ok ? ONE_K : k_q;

        if (sop_ok || data_ok) begin
            wen_d   = 1'b1;
            addr_d  = sop_ok ? (wr_ptr_q + ONE_A) : (wr_ptr_q + k_q[ADDR_W-1:0]);
            wdata_d = in_data;
            be_d    = in_eop ? eop_be : 4'b1111;
            k_d     = sop_ok ? TWO_K : (k_q + ONE_K);
            // Only the eop beat's value reaches the header; earlier beats are overwritten.
            len_d   = (16'(words) << 2) - {14'b0, in_empty};
        end

        if (state_q == HDR) begin
            wen_d        = 1'b1;
            addr_d       = wr_ptr_q;
            wdata_d      = {seq_q, len_q};
            be_d         = 4'b1111;
            wr_ptr_d     = wr_ptr_q + k_q[ADDR_W-1:0];
            frame_done_d = 1'b1;
            seq_d        = seq_q + 16'd1;
        end

        drop_inc = 2'(abort) + 2'(sop_beat & ~room_sop) + 2'(data_beat & ~room_data);
        drop_sum = {1'b0, drop_q} + {15'b0, drop_inc};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign wr_ptr     = wr_ptr_q;
    assign address    = addr_q;
    assign clken      = wen_q;
    assign chipselect = wen_q;
    assign write      = wen_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;
    assign frame_done = frame_done_q;
    assign drop_count = drop_q;

endmodule
